alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 133 +++++++++++++
 tb/tb_alu_seq.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: valid/ready ALU. Shifts are iterative at SHIFT_STEP bits per cycle.
// Define ALU_SEQ_BARREL_EN to use a single-cycle barrel shifter instead.
module alu_seq #(
    parameter int SHIFT_STEP = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  AluOp,
    input  logic [31:0] AluInput1,
    input  logic [31:0] AluInput2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] AluResult,
    output logic        Zero
);
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_SLL  = 4'b0010;
    localparam logic [3:0] OP_SLT  = 4'b0011;
    localparam logic [3:0] OP_SLTU = 4'b0100;
    localparam logic [3:0] OP_XOR  = 4'b0101;
    localparam logic [3:0] OP_SRL  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_OR   = 4'b1000;
    localparam logic [3:0] OP_AND  = 4'b1001;
    localparam logic [4:0] STEP    = 5'(SHIFT_STEP);

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_result;
    logic [4:0]  r_remaining;
    logic [3:0]  r_op;

    logic [4:0]  w_shamt;
    logic        w_is_shift;
    logic        w_start_shift;
    logic        w_accept;
    logic [31:0] w_alu_result;
    logic [4:0]  w_step;
    logic [31:0] w_shift_next;

    assign w_shamt    = AluInput2[4:0];
    assign w_is_shift = (AluOp == OP_SLL) || (AluOp == OP_SRL) || (AluOp == OP_SRA);
    assign w_accept   = in_valid && (r_state == IDLE);

`ifdef ALU_SEQ_BARREL_EN
    assign w_start_shift = 1'b0;
`else
    assign w_start_shift = w_is_shift && (w_shamt != 5'd0);
`endif

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_alu_result = '0;
        case (AluOp)
            OP_ADD:  w_alu_result = AluInput1 + AluInput2;
            OP_SUB:  w_alu_result = AluInput1 - AluInput2;
            OP_SLT:  w_alu_result = {31'd0, $signed(AluInput1) < $signed(AluInput2)};
            OP_SLTU: w_alu_result = {31'd0, AluInput1 < AluInput2};
            OP_XOR:  w_alu_result = AluInput1 ^ AluInput2;
            OP_OR:   w_alu_result = AluInput1 | AluInput2;
            OP_AND:  w_alu_result = AluInput1 & AluInput2;
`ifdef ALU_SEQ_BARREL_EN
            OP_SLL:  w_alu_result = AluInput1 << w_shamt;
            OP_SRL:  w_alu_result = AluInput1 >> w_shamt;
            OP_SRA:  w_alu_result = $unsigned($signed(AluInput1) >>> w_shamt);
`else
            // Only a zero-amount shift takes this path; the rest go through SHIFT.
            OP_SLL, OP_SRL, OP_SRA: w_alu_result = AluInput1;
`endif
            default: w_alu_result = '0;
        endcase
    end

    assign w_step = (r_remaining < STEP) ? r_remaining : STEP;

    always_comb begin
        w_shift_next = r_result >> w_step;
        if (r_op == OP_SLL) begin
            w_shift_next = r_result << w_step;
        end else if (r_op == OP_SRA) begin
            w_shift_next = $unsigned($signed(r_result) >>> w_step);
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_next_state = w_start_shift ? SHIFT : DONE;
            SHIFT:   if (r_remaining <= STEP) w_next_state = DONE;
            DONE:    if (out_ready) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result    <= '0;
            r_remaining <= '0;
            r_op        <= OP_ADD;
        end else if (w_accept) begin
            r_op <= AluOp;
            if (w_start_shift) begin
                r_result    <= AluInput1;
                r_remaining <= w_shamt;
            end else begin
                r_result    <= w_alu_result;
                r_remaining <= '0;
            end
        end else if (r_state == SHIFT) begin
            r_result    <= w_shift_next;
            r_remaining <= r_remaining - w_step;
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign AluResult = r_result;
    assign Zero      = (r_result == 32'd0);
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: two instances (SHIFT_STEP 1 and 4) share stimulus;
// a vector table checks results/latency, hand sequences cover stall and reset abort.
module tb_alu_seq;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [3:0]  AluOp;
    logic [31:0] AluInput1;
    logic [31:0] AluInput2;
    logic        in_ready1, out_valid1, zero1;
    logic        in_ready4, out_valid4, zero4;
    logic [31:0] result1, result4;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_seq #(.SHIFT_STEP(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .AluOp(AluOp), .AluInput1(AluInput1), .AluInput2(AluInput2),
        .out_valid(out_valid1), .out_ready(out_ready), .AluResult(result1), .Zero(zero1)
    );

    alu_seq #(.SHIFT_STEP(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
        .AluOp(AluOp), .AluInput1(AluInput1), .AluInput2(AluInput2),
        .out_valid(out_valid4), .out_ready(out_ready), .AluResult(result4), .Zero(zero4)
    );

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    localparam int NVEC = 20;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic int exp_latency(input logic [3:0] op, input logic [31:0] b, input int step);
        int shamt;
        shamt = int'(b[4:0]);
`ifdef ALU_SEQ_BARREL_EN
        return 1;
`else
        if ((op == 4'b0010 || op == 4'b0110 || op == 4'b0111) && shamt != 0)
            return 1 + (shamt + step - 1) / step;
        return 1;
`endif
    endfunction

    task automatic run_vec(input int idx, input vec_t v);
        int lat1, lat4, cyc;
        string tag;
        tag = $sformatf("vec%0d", idx);
        @(negedge clk);
        AluOp = v.op; AluInput1 = v.a; AluInput2 = v.b;
        in_valid = 1'b1; out_ready = 1'b0;
        check({tag, "_in_ready1"}, 32'(in_ready1), 32'd1);
        check({tag, "_in_ready4"}, 32'(in_ready4), 32'd1);
        @(posedge clk); #1;
        // Scramble operands after accept; they must not be resampled.
        in_valid = 1'b0; AluInput1 = ~v.a; AluInput2 = ~v.b; AluOp = 4'b0000;
        lat1 = 0; lat4 = 0; cyc = 1;
        while ((lat1 == 0 || lat4 == 0) && cyc <= 40) begin
            if (lat1 == 0 && out_valid1) lat1 = cyc;
            if (lat4 == 0 && out_valid4) lat4 = cyc;
            if (lat1 == 0 || lat4 == 0) begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        check({tag, "_lat1"}, 32'(lat1), 32'(exp_latency(v.op, v.b, 1)));
        check({tag, "_lat4"}, 32'(lat4), 32'(exp_latency(v.op, v.b, 4)));
        check({tag, "_res1"}, result1, v.exp);
        check({tag, "_res4"}, result4, v.exp);
        check({tag, "_zero1"}, 32'(zero1), 32'(v.exp == 32'd0));
        check({tag, "_zero4"}, 32'(zero4), 32'(v.exp == 32'd0));
        check({tag, "_busy1"}, 32'(in_ready1), 32'd0);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check({tag, "_drain_ov1"}, 32'(out_valid1), 32'd0);
        check({tag, "_drain_ov4"}, 32'(out_valid4), 32'd0);
        check({tag, "_idle4"}, 32'(in_ready4), 32'd1);
        out_ready = 1'b0;
    endtask

    initial begin
        int stray;
        vecs[0]  = '{4'b0000, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000};
        vecs[1]  = '{4'b0001, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000};
        vecs[2]  = '{4'b0011, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001};
        vecs[3]  = '{4'b0100, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
        vecs[4]  = '{4'b0111, 32'h8000_0000, 32'h0000_001F, 32'hFFFF_FFFF};
        vecs[5]  = '{4'b0010, 32'h0000_0001, 32'hFFFF_FFE0, 32'h0000_0001};
        vecs[6]  = '{4'b0110, 32'hF000_0000, 32'h0000_0006, 32'h03C0_0000};
        vecs[7]  = '{4'b0101, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0};
        vecs[8]  = '{4'b1000, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678};
        vecs[9]  = '{4'b1001, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'h0F0F_0000};
        vecs[10] = '{4'b0010, 32'h0000_0003, 32'h0000_0004, 32'h0000_0030};
        vecs[11] = '{4'b0110, 32'h8000_0000, 32'h0000_0021, 32'h4000_0000};
        vecs[12] = '{4'b0111, 32'h8000_0010, 32'h0000_0005, 32'hFC00_0000};
        vecs[13] = '{4'b0011, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[14] = '{4'b0100, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001};
        vecs[15] = '{4'b1010, 32'h1234_5678, 32'h1111_1111, 32'h0000_0000};
        vecs[16] = '{4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[17] = '{4'b0001, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF};
        vecs[18] = '{4'b0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
        vecs[19] = '{4'b0010, 32'hFFFF_FFFF, 32'h0000_001F, 32'h8000_0000};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        AluOp = 4'b0000; AluInput1 = '0; AluInput2 = '0;
        #1;
        check("rst_ov1", 32'(out_valid1), 32'd0);
        check("rst_res1", result1, 32'd0);
        check("rst_zero1", 32'(zero1), 32'd1);
        check("rst_in_ready1", 32'(in_ready1), 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) run_vec(i, vecs[i]);

        // Stall in DONE with a new request pending; it must wait for the drain.
        @(negedge clk);
        AluOp = 4'b0000; AluInput1 = 32'd10; AluInput2 = 32'd20;
        in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        AluInput1 = 32'd1; AluInput2 = 32'd2;
        for (int c = 0; c < 5; c++) begin
            check($sformatf("stall%0d_ov", c), 32'(out_valid1), 32'd1);
            check($sformatf("stall%0d_in_ready", c), 32'(in_ready1), 32'd0);
            check($sformatf("stall%0d_res1", c), result1, 32'd30);
            check($sformatf("stall%0d_res4", c), result4, 32'd30);
            @(posedge clk); #1;
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("drain_in_ready", 32'(in_ready1), 32'd1);
        check("drain_ov", 32'(out_valid1), 32'd0);
        out_ready = 1'b0;
        @(posedge clk); #1;
        check("next_ov", 32'(out_valid1), 32'd1);
        check("next_res", result1, 32'd3);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Reset in the middle of a long shift aborts it.
        @(negedge clk);
        AluOp = 4'b0111; AluInput1 = 32'h8000_0000; AluInput2 = 32'h0000_001F;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_ov1", 32'(out_valid1), 32'd0);
        check("abort_ov4", 32'(out_valid4), 32'd0);
        check("abort_res1", result1, 32'd0);
        check("abort_zero1", 32'(zero1), 32'd1);
        check("abort_in_ready1", 32'(in_ready1), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        stray = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (out_valid1 || out_valid4) stray++;
        end
        check("abort_no_stale", 32'(stray), 32'd0);
        out_ready = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
